plru_state_ctrl: RTL and testbench
==================================

PLRU_STATE_CTRL -- requirements
Module: plru_state_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SETS, 64, number of cache sets (power of two, >=2).
REQ-002 SHALL provide parameter ASSOCIATIVITY, 4, ways per set; only 4 supported, state width 3 bits, way width 2 bits.
REQ-003 SHALL provide ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- ready  out  1  state array initialised; lookups/touches accepted.
- flush_req  in  1  one-cycle pulse; re-initialise all sets.
- lookup_valid  in  1  read request.
- lookup_index  in  log2(NUM_SETS)  set to read.
- lookup_rvalid  out  1  lookup result valid.
- lookup_plru  out  3  PLRU state of looked-up set.
- touch_valid  in  1  hit/fill update request.
- touch_index  in  log2(NUM_SETS)  set to update.
- touch_way  in  2  way accessed.
- plru_old  out  3  current state of pending-update set, to external PLRU decoder.
- hit_line  out  2  way of pending update, to external PLRU decoder.
- plru_new  in  3  updated state returned combinationally by decoder.

Function
REQ-004 SHALL hold one 3-bit state per set in flops.
REQ-005 SHALL implement FSM states INIT and RUN; INIT writes 3'b000 to set sweep_cnt each cycle, sweep_cnt counts 0..NUM_SETS-1, and the cycle after writing set NUM_SETS-1 the FSM enters RUN.
REQ-006 ready SHALL be 1 only in RUN.
REQ-007 In RUN, touch_valid SHALL register {touch_index, touch_way} into a single update stage (stage U) at the clock edge.
REQ-008 While stage U valid, plru_old SHALL equal array[U.index] and hit_line U.way; plru_new SHALL be written to array[U.index] at the end of that cycle (update visible in array 2 edges after touch presented).
REQ-009 When stage U invalid, plru_old and hit_line SHALL be 0.
REQ-010 In RUN, lookup_valid SHALL produce lookup_rvalid=1 and lookup_plru one cycle later (registered), from array[lookup_index].
REQ-011 Back-to-back touches to the same set SHALL need no stall: stage U reads the array after the previous write completed.
REQ-012 Simultaneous touch and lookup of any indices SHALL both be accepted; no backpressure exists.
REQ-013 In INIT, touch_valid and lookup_valid SHALL be ignored; lookup_rvalid stays 0 and stage U stays invalid.
REQ-014 flush_req in RUN SHALL move the FSM to INIT at the next edge with sweep_cnt=0; a stage U write in that cycle is performed and later overwritten; a lookup in that cycle still returns.
REQ-015 flush_req in INIT SHALL be ignored.

Reset
REQ-016 resetn=0 at an edge SHALL clear stage U valid, lookup_rvalid, lookup_plru and sweep_cnt to 0 and set FSM to INIT; ready=0.
REQ-017 Reset asserted mid-INIT SHALL restart the sweep at set 0.
REQ-018 Array contents SHALL be established only by the INIT sweep, not by reset directly.

Configuration
REQ-019 Macro PLRU_STATE_CTRL_BYPASS_EN defined: a lookup whose index equals a valid stage U index in the same cycle SHALL return plru_new.
REQ-020 Macro undefined: such a lookup SHALL return the pre-update array value; all else identical.

Verification (NUM_SETS=64, PLRU decoder attached)
REQ-021 Release resetn -> ready=0 for 64 cycles, 1 on cycle 65; lookup set 5 -> lookup_plru=3'b000 next cycle.
REQ-022 Touch set 3 way 0 -> next cycle plru_old=000, hit_line=0, plru_new=011; lookup set 3 two cycles after touch -> 3'b011.
REQ-023 Touch set 3 way 0 then set 3 way 2 on consecutive cycles -> array[3] = 011 then 110; later lookup set 3 -> 3'b110.
REQ-024 From reset state, touch set 7 way 1 at cycle t, lookup set 7 at t+1 -> 3'b001 with PLRU_STATE_CTRL_BYPASS_EN, 3'b000 without; lookup at t+2 -> 3'b001 in both builds.
REQ-025 After touches, pulse flush_req -> ready=0 next cycle for 64 cycles; subsequent lookups of sets 0, 3, 63 -> 3'b000.
REQ-026 Assert resetn=0 at sweep_cnt=20 for one cycle -> ready returns 64 cycles after release, not 44.

Source files
------------

// File: rtl/plru_state_ctrl_if.sv
// plru_state_ctrl_if: lookup, touch and external PLRU decoder signals of plru_state_ctrl
interface plru_state_ctrl_if #(parameter int NUM_SETS = 64);
  localparam int IDX_W = $clog2(NUM_SETS);
  logic             ready;
  logic             flush_req;
  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_index;
  logic             lookup_rvalid;
  logic [2:0]       lookup_plru;
  logic             touch_valid;
  logic [IDX_W-1:0] touch_index;
  logic [1:0]       touch_way;
  logic [2:0]       plru_old;
  logic [1:0]       hit_line;
  logic [2:0]       plru_new;
  modport master (
    input  ready, lookup_rvalid, lookup_plru, plru_old, hit_line,
    output flush_req, lookup_valid, lookup_index, touch_valid, touch_index, touch_way, plru_new
  );
  modport slave (
    output ready, lookup_rvalid, lookup_plru, plru_old, hit_line,
    input  flush_req, lookup_valid, lookup_index, touch_valid, touch_index, touch_way, plru_new
  );
endinterface

// File: rtl/plru_state_ctrl.sv
// plru_state_ctrl: per-set 3-bit tree-PLRU state array with init sweep, update stage and registered lookup.
// Define PLRU_STATE_CTRL_BYPASS_EN to forward plru_new to a same-cycle lookup of the set being updated.
module plru_state_ctrl #(
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 4
) (
  input logic clk,
  input logic resetn,
  plru_state_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(ASSOCIATIVITY);
  typedef enum logic {INIT, RUN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             u_vld_q, u_vld_d;
  logic [IDX_W-1:0] u_idx_q, u_idx_d;
  logic [WAY_W-1:0] u_way_q, u_way_d;
  logic             rvalid_q, rvalid_d;
  logic [2:0]       lplru_q, lplru_d;
  logic [2:0]       mem_q [NUM_SETS];
  logic [2:0]       mem_d [NUM_SETS];
  logic [2:0]       rd_val;
  logic             run;
`ifdef PLRU_STATE_CTRL_BYPASS_EN
  assign rd_val = (u_vld_q && u_idx_q == bus.lookup_index) ? bus.plru_new : mem_q[bus.lookup_index];
`else
  assign rd_val = mem_q[bus.lookup_index];
`endif
  assign run = state_q == RUN;
  always_comb begin
    state_d     = run ? (bus.flush_req ? INIT : RUN)
                      : (sweep_cnt_q == IDX_W'(NUM_SETS - 1) ? RUN : INIT);
    sweep_cnt_d = run ? '0 : sweep_cnt_q + 1'b1;
    // a touch arriving with flush would land in INIT, so it is dropped
    u_vld_d     = run && bus.touch_valid && !bus.flush_req;
    u_idx_d     = bus.touch_index;
    u_way_d     = bus.touch_way;
    rvalid_d    = run && bus.lookup_valid;
    lplru_d     = rvalid_d ? rd_val : lplru_q;
    mem_d       = mem_q;
    if (!run) mem_d[sweep_cnt_q] = '0;
    else if (u_vld_q) mem_d[u_idx_q] = bus.plru_new;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= INIT;
      sweep_cnt_q <= '0;
      u_vld_q     <= 1'b0;
      u_idx_q     <= '0;
      u_way_q     <= '0;
      rvalid_q    <= 1'b0;
      lplru_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      u_vld_q     <= u_vld_d;
      u_idx_q     <= u_idx_d;
      u_way_q     <= u_way_d;
      rvalid_q    <= rvalid_d;
      lplru_q     <= lplru_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.ready         = run;
  assign bus.lookup_rvalid = rvalid_q;
  assign bus.lookup_plru   = lplru_q;
  assign bus.plru_old      = u_vld_q ? mem_q[u_idx_q] : 3'b000;
  assign bus.hit_line      = u_vld_q ? u_way_q : '0;
endmodule

// File: tb/tb_plru_state_ctrl.sv
// tb_plru_state_ctrl: directed bench with a reference model of the PLRU state array and an attached tree decoder.
module tb_plru_state_ctrl;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;
  plru_state_ctrl_if #(.NUM_SETS(64)) bus ();
  plru_state_ctrl #(.NUM_SETS(64), .ASSOCIATIVITY(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
`ifdef PLRU_STATE_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // tree PLRU: bit0 root (1 = victim on right), bit1 left pair, bit2 right pair
  function automatic logic [2:0] plru_next(logic [2:0] s, logic [1:0] w);
    return w[1] ? {~w[0], s[1], 1'b0} : {s[2], ~w[0], 1'b1};
  endfunction
  always_comb bus.plru_new = plru_next(bus.plru_old, bus.hit_line);
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [2:0] arr [64];
  int         init_left;
  bit         pv, e_rv, mv;
  int         pidx, pway;
  logic [2:0] e_lp;
  always @(posedge clk) begin
    if (!resetn) begin
      mv = 1; init_left = 64; pv = 0; e_rv = 0; e_lp = 0;
      foreach (arr[i]) arr[i] = 0;
    end else if (init_left > 0) begin
      init_left--; pv = 0; e_rv = 0;
    end else begin
      e_rv = bus.lookup_valid;
      if (bus.lookup_valid)
        e_lp = (BYP && pv && pidx == int'(bus.lookup_index)) ? plru_next(arr[pidx], 2'(pway))
                                                             : arr[bus.lookup_index];
      if (pv) arr[pidx] = plru_next(arr[pidx], 2'(pway));
      pv = bus.touch_valid && !bus.flush_req;
      pidx = int'(bus.touch_index);
      pway = int'(bus.touch_way);
      if (bus.flush_req) begin
        init_left = 64;
        foreach (arr[i]) arr[i] = 0;
      end
    end
  end
  always @(negedge clk) if (mv) begin
    chk("ready", 32'(bus.ready), 32'(init_left == 0));
    chk("lookup_rvalid", 32'(bus.lookup_rvalid), 32'(e_rv));
    chk("lookup_plru", 32'(bus.lookup_plru), 32'(e_lp));
    chk("plru_old", 32'(bus.plru_old), pv ? 32'(arr[pidx]) : 32'd0);
    chk("hit_line", 32'(bus.hit_line), pv ? 32'(pway) : 32'd0);
  end
  task automatic idle();
    bus.flush_req = 0; bus.touch_valid = 0; bus.lookup_valid = 0;
    bus.touch_index = 0; bus.touch_way = 0; bus.lookup_index = 0;
  endtask
  task automatic touch(int idx, int way);
    bus.touch_valid = 1; bus.touch_index = 6'(idx); bus.touch_way = 2'(way);
  endtask
  task automatic lookup(int idx);
    bus.lookup_valid = 1; bus.lookup_index = 6'(idx);
  endtask
  task automatic wait_ready(string name);
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'd64);
  endtask
  task automatic lookup_chk(string name, int idx, logic [2:0] exp);
    lookup(idx);
    @(negedge clk);
    idle();
    chk({name, "_rvalid"}, 32'(bus.lookup_rvalid), 32'd1);
    chk(name, 32'(bus.lookup_plru), 32'(exp));
  endtask
  initial begin
    resetn = 0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'd0);
    chk("reset_rvalid", 32'(bus.lookup_rvalid), 32'd0);
    resetn = 1;
    wait_ready("init_latency");
    lookup_chk("lk5", 5, 3'b000);
    touch(3, 0);
    @(negedge clk);
    idle();
    chk("t3_old", 32'(bus.plru_old), 32'd0);
    chk("t3_hit", 32'(bus.hit_line), 32'd0);
    chk("t3_new", 32'(bus.plru_new), 32'b011);
    @(negedge clk);
    lookup_chk("lk3", 3, 3'b011);
    touch(3, 0);
    @(negedge clk);
    touch(3, 2);
    @(negedge clk);
    idle();
    chk("b2b_old", 32'(bus.plru_old), 32'b011);
    chk("b2b_hit", 32'(bus.hit_line), 32'd2);
    chk("b2b_new", 32'(bus.plru_new), 32'b110);
    @(negedge clk);
    lookup_chk("lk3b", 3, 3'b110);
    touch(7, 1);
    @(negedge clk);
    idle();
    lookup(7);
    @(negedge clk);
    chk("byp_lk7", 32'(bus.lookup_plru), BYP ? 32'b001 : 32'b000);
    lookup(7);
    @(negedge clk);
    idle();
    chk("post_lk7", 32'(bus.lookup_plru), 32'b001);
    for (int i = 0; i < 40; i++) begin
      bus.touch_valid = 1'($urandom);
      bus.touch_index = 6'($urandom_range(8, 15));
      bus.touch_way = 2'($urandom);
      bus.lookup_valid = 1'($urandom);
      bus.lookup_index = 6'($urandom_range(8, 15));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    bus.flush_req = 1;
    touch(9, 0);
    lookup(3);
    @(negedge clk);
    idle();
    chk("flush_ready", 32'(bus.ready), 32'd0);
    chk("flush_rvalid", 32'(bus.lookup_rvalid), 32'd1);
    chk("flush_lp", 32'(bus.lookup_plru), 32'b110);
    begin
      int n = 0;
      while (!bus.ready && n < 200) begin
        @(negedge clk);
        n++;
        idle();
        if (n == 5) begin touch(3, 1); lookup(3); end
        if (n == 10) bus.flush_req = 1;
      end
      idle();
      chk("flush_latency", 32'(n), 32'd64);
    end
    lookup_chk("fl0", 0, 3'b000);
    lookup_chk("fl3", 3, 3'b000);
    lookup_chk("fl63", 63, 3'b000);
    lookup_chk("fl9", 9, 3'b000);
    touch(20, 3);
    bus.flush_req = 1;
    @(negedge clk);
    idle();
    repeat (20) @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    wait_ready("mid_rst_latency");
    lookup_chk("lk20", 20, 3'b000);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
